// File: rtl/huff_stream_ctrl.sv
// Sequencing controller for a serial Huffman decoder: serialises packed words
// into the decoder, owns its reset, and buffers decoded symbols in a FIFO.
module huff_stream_ctrl #(
    parameter int WORD_W = 32,
    parameter int LEN_W  = 6,
    parameter int DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W-1:0]        in_data,
    input  logic [LEN_W-1:0]         in_len,
    output logic                     dec_x,
    output logic                     dec_rst,
    input  logic [2:0]               dec_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_sym,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     err_partial
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CMP_W = ((LEN_W > CNT_W) ? LEN_W : CNT_W) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WORD_W-1:0]  shift_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx_q;
    logic               dec_rst_q;
    logic               err_q;

    logic [2:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic [LEN_W-1:0]   eff_len;
    logic [CMP_W-1:0]   free_slots;
    logic               accept;
    logic               last_bit;
    logic               push;
    logic               pop;
    logic               set_err;

    // Admission: a word of n bits yields at most n symbols, so requiring n free
    // slots up front guarantees the FIFO can never overflow mid-word.
    assign eff_len    = (in_len > LEN_W'(WORD_W)) ? LEN_W'(WORD_W) : in_len;
    assign free_slots = CMP_W'(DEPTH) - CMP_W'(count_q);
    assign in_ready   = (state_q == IDLE) && (free_slots >= CMP_W'(eff_len));
    assign accept     = in_valid && in_ready;
    assign last_bit   = (idx_q == len_q - LEN_W'(1));

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        set_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && (eff_len != '0)) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // dec_y seen in cycle 0 belongs to the reset period, not this word
                if ((idx_q != '0) && (dec_y != 3'd0)) begin
                    push = 1'b1;
                end
                if (last_bit) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (dec_y != 3'd0) begin
                    push = 1'b1;
                end else begin
                    set_err = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dec_rst_q <= 1'b1;
            shift_q   <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dec_rst_q <= (state_d == IDLE);
            if ((state_q == IDLE) && accept) begin
                shift_q <= in_data;
                len_q   <= eff_len;
                idx_q   <= '0;
            end else if (state_q == SHIFT) begin
                shift_q <= shift_q << 1;
                idx_q   <= idx_q + LEN_W'(1);
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign pop = out_ready && (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= dec_y;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dec_x       = (state_q == SHIFT) && shift_q[WORD_W-1];
    assign dec_rst     = dec_rst_q;
    assign out_valid   = (count_q != '0);
    assign out_sym     = out_valid ? mem[rd_ptr_q] : 3'b000;
    assign fifo_count  = count_q;
    assign busy        = (state_q != IDLE);
    assign err_partial = err_q;

endmodule

// File: tb/tb_huff_stream_ctrl.sv
// Self-checking bench for huff_stream_ctrl with a behavioural Huffman decoder
// and a symbol scoreboard.
module tb_huff_stream_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [5:0]  in_len = 6'd32;
    logic        dec_x;
    logic        dec_rst;
    logic [2:0]  dec_y;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_sym;
    logic [5:0]  fifo_count;
    logic        busy;
    logic        err_partial;

    int          compared = 0;
    int          mismatched = 0;
    logic [2:0]  sb [$];

    localparam logic [31:0] FEED = 32'hCDDF19A0;
    localparam logic [31:0] DEAD = 32'hFAF77700;

    huff_stream_ctrl #(.WORD_W(32), .LEN_W(6), .DEPTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_len(in_len),
        .dec_x(dec_x), .dec_rst(dec_rst), .dec_y(dec_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
        .fifo_count(fifo_count), .busy(busy), .err_partial(err_partial)
    );

    always #5 clk = ~clk;

    // Behavioural decoder: A=0 B=101 C=100 D=111 E=1101 F=1100, registered y.
    logic [3:0] pre;
    int         plen;
    always @(posedge clk) begin : decoder_model
        logic [3:0] nb;
        int         n;
        logic [2:0] sym;
        if (dec_rst) begin
            pre = '0;
            plen = 0;
            dec_y <= 3'd0;
        end else begin
            nb = {pre[2:0], dec_x};
            n = plen + 1;
            sym = 3'd0;
            if (n == 1 && nb == 4'b0000) sym = 3'd1;
            else if (n == 3 && nb[2:0] == 3'b101) sym = 3'd2;
            else if (n == 3 && nb[2:0] == 3'b100) sym = 3'd3;
            else if (n == 3 && nb[2:0] == 3'b111) sym = 3'd4;
            else if (n == 4 && nb == 4'b1101) sym = 3'd5;
            else if (n == 4 && nb == 4'b1100) sym = 3'd6;
            if (sym != 3'd0 || n >= 4) begin
                pre = '0;
                plen = 0;
            end else begin
                pre = nb;
                plen = n;
            end
            dec_y <= sym;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard pop: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            compared++;
            assert (sb.size() != 0) else begin
                mismatched++;
                $error("[TB] FAIL unexpected_pop: observed sym %0d expected no symbol", out_sym);
            end
            if (sb.size() != 0) check("sym", {29'd0, out_sym}, {29'd0, sb.pop_front()});
        end
    end

    task automatic push_syms(input logic [2:0] s [$]);
        foreach (s[i]) sb.push_back(s[i]);
    endtask

    task automatic send_word(input logic [31:0] d, input logic [5:0] l, input string tag);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data = d;
        in_len = l;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, sb.size(), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        int m;
        logic seen;
        logic [2:0] feed_syms [$];
        logic [2:0] dead_syms [$];
        logic [2:0] a_syms [$];
        feed_syms = '{3'd6, 3'd5, 3'd5, 3'd4, 3'd3, 3'd1, 3'd6, 3'd5};
        dead_syms = '{3'd4, 3'd5, 3'd1, 3'd4, 3'd2, 3'd5, 3'd5, 3'd6};
        a_syms = '{};
        for (int i = 0; i < 32; i++) a_syms.push_back(3'd1);

        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_dec_rst", {31'd0, dec_rst}, 32'd1);
        check("rst_dec_x", {31'd0, dec_x}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sym", {29'd0, out_sym}, 32'd0);
        check("rst_fifo_count", {26'd0, fifo_count}, 32'd0);
        check("rst_err", {31'd0, err_partial}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("[TB] back-to-back FEEDCAFE / DEADBEEF");
        out_ready = 1'b1;
        push_syms(feed_syms);
        push_syms(dead_syms);
        send_word(FEED, 6'd27, "feed_accept");
        in_valid = 1'b1;
        in_data = DEAD;
        in_len = 6'd26;
        count_busy(n);
        check("feed_busy_cycles", n, 32'd28);
        m = 0;
        while (!busy && dec_rst && m < 10) begin
            m++;
            @(negedge clk);
        end
        check("gap_dec_rst_cycles", m, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        count_busy(n);
        wait_drain("feed_dead_drain");
        check("feed_dead_err", {31'd0, err_partial}, 32'd0);

        $display("[TB] backpressure and full FIFO");
        @(posedge clk); #1;
        out_ready = 1'b0;
        push_syms(a_syms);
        send_word(32'h0, 6'd32, "zeros_accept");
        count_busy(n);
        check("zeros_busy_cycles", n, 32'd33);
        check("full_count", {26'd0, fifo_count}, 32'd32);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data = 32'h0;
        in_len = 6'd1;
        repeat (3) @(negedge clk);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        sb.push_back(3'd1);
        @(negedge clk);
        check("after_pop_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        count_busy(n);
        check("refill_count", {26'd0, fifo_count}, 32'd32);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain("full_drain");

        $display("[TB] partial codeword");
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_word(32'hC0000000, 6'd2, "partial_accept");
        count_busy(n);
        check("partial_busy_cycles", n, 32'd3);
        check("partial_count", {26'd0, fifo_count}, 32'd0);
        check("partial_err", {31'd0, err_partial}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_syms(feed_syms);
        send_word(FEED, 6'd27, "clean_accept");
        count_busy(n);
        wait_drain("clean_drain");
        check("err_sticky", {31'd0, err_partial}, 32'd1);

        $display("[TB] reset mid-word");
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_word(FEED, 6'd27, "abort_accept");
        repeat (10) @(posedge clk);
        #1;
        check("abort_pre_count", {26'd0, fifo_count}, 32'd2);
        check("abort_pre_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_dec_rst", {31'd0, dec_rst}, 32'd1);
        check("abort_count", {26'd0, fifo_count}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_err_clear", {31'd0, err_partial}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        push_syms(feed_syms);
        send_word(FEED, 6'd27, "resend_accept");
        count_busy(n);
        check("resend_busy_cycles", n, 32'd28);
        wait_drain("resend_drain");

        $display("[TB] length edges");
        send_word(32'h12345678, 6'd0, "len0_accept");
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check("len0_busy", {31'd0, seen}, 32'd0);
        check("len0_count", {26'd0, fifo_count}, 32'd0);
        push_syms(feed_syms);
        for (int i = 0; i < 5; i++) sb.push_back(3'd1);
        send_word(FEED, 6'd40, "len40_accept");
        count_busy(n);
        check("len40_busy_cycles", n, 32'd33);
        wait_drain("len40_drain");
        check("len40_err", {31'd0, err_partial}, 32'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/huff_stream_ctrl.md
# huff_stream_ctrl

Sequencing controller for the serial `huffman_decoder`. It accepts left-justified packed Huffman bitstream words over a valid/ready handshake and feeds them one bit per clock into the decoder. It collects the decoder's 3-bit symbol outputs into an internal FIFO and presents them downstream over a second valid/ready handshake. It owns the decoder's reset, holding it at the code-tree root between words, and never accepts a word whose worst-case symbol count could overflow the FIFO.

## Interface
- `WORD_W`, 32: max bitstream word width in bits.
- `LEN_W`, 6: width of `in_len`; must hold the value `WORD_W`.
- `DEPTH`, 32: symbol FIFO entries; a power of two, and ≥ `WORD_W`.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  the word on `in_data`/`in_len` is offered.
- `in_ready`  out  1  the word is accepted at a rising edge where `in_valid && in_ready`.
- `in_data`  in  `WORD_W`  bitstream, first bit = `in_data[WORD_W-1]`.
- `in_len`  in  `LEN_W`  number of valid bits; values > `WORD_W` are treated as `WORD_W`.
- `dec_x`  out  1  serial bit to the decoder's `x`.
- `dec_rst`  out  1  drives the decoder's `reset`; registered, so glitch-free.
- `dec_y`  in  3  decoder's `y`: 000 = no symbol, 1..6 = A..F.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  downstream pop.
- `out_sym`  out  3  FIFO head symbol, 1..6.
- `fifo_count`  out  clog2(`DEPTH`)+1  occupied entries.
- `busy`  out  1  state ≠ IDLE.
- `err_partial`  out  1  sticky: a word ended mid-codeword.

## Operation
- Decoder contract:
  - Code set: A=0, B=101, C=100, D=111, E=1101, F=1100.
  - `y` is registered. It is nonzero for exactly the one cycle following the edge that sampled a codeword's final bit.
  - The decoder returns to the root itself after each codeword.
- States: IDLE, SHIFT, DRAIN.
- IDLE:
  - `dec_rst`=1, `dec_x`=0.
  - `in_ready` = (free ≥ min(`in_len`,`WORD_W`)), where free = `DEPTH` − `fifo_count` sampled this cycle. A pop in the same cycle does not count.
  - On accept with effective len 0: the word is consumed, state stays IDLE, no decoder activity.
  - On accept with len ≥ 1: load shift register and bit counter, go to SHIFT.
- SHIFT, cycle k = 0..len−1:
  - `dec_rst`=0, `dec_x` = bit k.
  - At the edge ending cycle k ≥ 1, a nonzero `dec_y` is pushed into the FIFO.
  - After cycle len−1, go to DRAIN.
- DRAIN (one cycle):
  - `dec_rst`=0, `dec_x`=0.
  - At the ending edge, a nonzero `dec_y` is pushed. If `dec_y`=000, set `err_partial`.
  - `dec_rst` reasserts at that edge; go to IDLE.
- FIFO:
  - Push and pop in the same cycle are both honoured.
  - Overflow cannot occur, by the admission rule, because a word yields ≤ len symbols.
  - A pop when empty is ignored.
  - Pointers wrap modulo `DEPTH`.
- `err_partial` clears only on `reset`.

## Timing
- Reset values: state IDLE, `dec_rst`=1, `dec_x`=0, FIFO empty, `out_valid`=0, `out_sym`=000, `fifo_count`=0, `busy`=0, `err_partial`=0, `in_ready`=1 for `in_len` ≤ `DEPTH`.
- Reset mid-word: the word is dropped, FIFO contents are discarded, `dec_rst`=1 immediately (asynchronous), state IDLE.
- Word occupancy: `busy` is high for len+1 cycles (len SHIFT + 1 DRAIN). The next accept is possible in the first IDLE cycle, so back-to-back words are separated by exactly one IDLE cycle with `dec_rst`=1.
- Symbol latency: a codeword ending on bit k is pushed at the edge ending cycle k+1; `out_valid`/`out_sym` reflect it from the following cycle (FIFO was empty).
- `in_ready` is low throughout SHIFT/DRAIN and never depends on `out_ready` combinationally.

## Test plan
- FEEDCAFE: `in_data`=0xCDDF19A0, `in_len`=27, `out_ready`=1 → symbols 6,5,5,4,3,1,6,5 in order; `busy` high 28 cycles; `err_partial`=0.
- DEADBEEF: `in_data`=0xFAF77700, `in_len`=26, sent back-to-back after FEEDCAFE → 4,5,1,4,2,5,5,6 follow with no loss; exactly one `dec_rst`=1 cycle between the words.
- Backpressure and full: `out_ready`=0, `in_data`=0, `in_len`=32 → 32 A symbols, `fifo_count`=32. The next offered word with `in_len`=1 sees `in_ready`=0 until one pop, then is accepted.
- Partial codeword: `in_data`=0xC0000000, `in_len`=2 → no push, `err_partial`=1 and stays 1 through a later clean word.
- Reset mid-word: assert `reset` at SHIFT cycle 10 of FEEDCAFE → `fifo_count`=0, `dec_rst`=1 within the same cycle, `busy`=0; a re-sent FEEDCAFE decodes correctly.
- Length edges: `in_len`=0 → accepted, `busy` stays 0, no push. `in_len`=40 → behaves as 32.
